viking_fb_writer: RTL

// - Write-side engine for the Viking 1280x1024 mono framebuffer.
// - Host (IO controller / blitter) pushes 16-bit pixel words. Pushes are buffered in a FIFO.
// - Each queued word is written to ST RAM only in the designated bus slot, so it never

---
 rtl/viking_fb_writer_if.sv | 25 ++
 rtl/viking_fb_writer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/viking_fb_writer_if.sv
// Host-side word write port of the Viking framebuffer writer.
// The host (master) offers words; the writer (slave) accepts them when wr_ready is high.
interface viking_fb_writer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_offset;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;

  modport master (
    output wr_valid,
    output wr_offset,
    output wr_data,
    output wr_be,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_offset,
    input  wr_data,
    input  wr_be,
    output wr_ready
  );
endinterface

// File: rtl/viking_fb_writer.sv
// Viking 1280x1024 mono framebuffer write engine: queued host words and a full clear,
// written to ST RAM only in bus slot WR_SLOT. Optional offset check: VIKING_FB_BOUNDS_EN.
module viking_fb_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  WR_SLOT    = 2'd1,
  parameter int unsigned FB_WORDS   = 81920
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 himem,
  input  logic [1:0]           bus_cycle,
  viking_fb_writer_if.slave    wr,
  input  logic                 clr_start,
  input  logic [15:0]          clr_value,
  output logic                 busy,
  output logic [22:0]          ram_addr,
  output logic [15:0]          ram_data,
  output logic                 ram_we,
  output logic [1:0]           ram_be,
  output logic                 err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam logic [1:0]  ISSUE_SLOT = WR_SLOT - 2'd1;

  state_t        state_r;
  state_t        state_s;
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [34:0]   fifo_mem_r [FIFO_DEPTH];
  logic [34:0]   fifo_rd_s;
  logic          empty_s;
  logic          full_s;
  logic          ready_s;
  logic          xfer_s;
  logic          oob_s;
  logic          push_s;
  logic          slot_s;
  logic          drain_issue_s;
  logic          clr_issue_s;
  logic          clr_done_s;
  logic          clr_accept_s;
  logic          clr_defer_s;
  logic          clr_pend_r;
  logic [15:0]   clr_val_r;
  logic [17:0]   clr_off_r;
  logic [22:0]   base_s;
  logic          ram_we_r;
  logic [22:0]   ram_addr_r;
  logic [15:0]   ram_data_r;
  logic [1:0]    ram_be_r;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign fifo_rd_s = fifo_mem_r[rd_ptr_r[AW-1:0]];

  assign ready_s = !full_s && !clr_pend_r && (state_r != ST_CLEAR);
  assign xfer_s  = wr.wr_valid && ready_s;

`ifdef VIKING_FB_BOUNDS_EN
  assign oob_s = ({1'b0, wr.wr_offset} >= 18'(FB_WORDS));
`else
  assign oob_s = 1'b0;
`endif

  // Words with no byte lanes (or out of range) are accepted but never queued.
  assign push_s = xfer_s && (wr.wr_be != 2'b00) && !oob_s;

  assign slot_s        = (bus_cycle == ISSUE_SLOT);
  assign drain_issue_s = (state_r == ST_DRAIN) && slot_s && !empty_s;
  assign clr_done_s    = (clr_off_r == 18'(FB_WORDS));
  assign clr_issue_s   = (state_r == ST_CLEAR) && slot_s && !clr_done_s;
  assign clr_accept_s  = clr_start && !clr_pend_r && (state_r != ST_CLEAR);
  assign clr_defer_s   = clr_accept_s && (!empty_s || push_s);
  assign base_s        = himem ? 23'h740000 : 23'h600000;

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_accept_s && !clr_defer_s) begin
          state_s = ST_CLEAR;
        end else if (clr_pend_r && empty_s) begin
          state_s = ST_CLEAR;
        end else if (!empty_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (empty_s) begin
          if (clr_pend_r || (clr_accept_s && !clr_defer_s)) begin
            state_s = ST_CLEAR;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        // Leave one slot after the final word so busy spans the whole last write.
        if (slot_s && clr_done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, FIFO pointers and clear bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      clr_pend_r <= 1'b0;
      clr_val_r  <= 16'h0000;
      clr_off_r  <= 18'd0;
    end else begin
      state_r <= state_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (drain_issue_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (state_s == ST_CLEAR) begin
        clr_pend_r <= 1'b0;
      end else if (clr_defer_s) begin
        clr_pend_r <= 1'b1;
      end
      if (clr_accept_s) begin
        clr_val_r <= clr_value;
      end
      if (state_r != ST_CLEAR) begin
        clr_off_r <= 18'd0;
      end else if (clr_issue_s) begin
        clr_off_r <= clr_off_r + 18'd1;
      end
    end
  end

  // FIFO storage: {be, data, offset}.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= {wr.wr_be, wr.wr_data, wr.wr_offset};
    end
  end

  // RAM port: loaded one edge before WR_SLOT, so the strobe covers exactly that slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_we_r   <= 1'b0;
      ram_addr_r <= 23'h000000;
      ram_data_r <= 16'h0000;
      ram_be_r   <= 2'b00;
    end else begin
      ram_we_r <= drain_issue_s || clr_issue_s;
      if (drain_issue_s) begin
        ram_addr_r <= base_s + {6'd0, fifo_rd_s[16:0]};
        ram_data_r <= fifo_rd_s[32:17];
        ram_be_r   <= fifo_rd_s[34:33];
      end else if (clr_issue_s) begin
        ram_addr_r <= base_s + {5'd0, clr_off_r};
        ram_data_r <= clr_val_r;
        ram_be_r   <= 2'b11;
      end
    end
  end

`ifdef VIKING_FB_BOUNDS_EN
  logic err_r;

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else if (xfer_s && oob_s) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign wr.wr_ready = ready_s;
  assign busy        = (state_r != ST_IDLE) || !empty_s || clr_pend_r;
  assign ram_we      = ram_we_r;
  assign ram_addr    = ram_addr_r;
  assign ram_data    = ram_data_r;
  assign ram_be      = ram_be_r;

endmodule
